// File: rtl/hood_runtime_ctrl.sv
// hood_runtime_ctrl: range-hood fan controller. It arbitrates the mode request,
// runs a limited-use boost countdown, accumulates run time in BCD mm:ss and
// raises a cleaning reminder.
// Optional feature macro: BOOST_REARM_EN (clear_run also rearms boost uses).
module hood_runtime_ctrl #(
  parameter int unsigned TICK_DIV   = 500,
  parameter int unsigned LEVELS     = 3,
  parameter int unsigned BOOST_SEC  = 60,
  parameter int unsigned BOOST_USES = 1,
  parameter int unsigned MAX_MIN    = 99,
  parameter int unsigned REMIND_MIN = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mode_req,
  input  logic        clear_run,
  output logic [2:0]  fan_level,
  output logic        boost_active,
  output logic        boost_locked,
  output logic        disp_sel,
  output logic [15:0] disp_bcd,
  output logic        remind,
  output logic        tick
);

  // Elaboration-time conversion of a seconds count to packed BCD mm:ss.
  function automatic logic [15:0] sec_to_bcd(input int unsigned s);
    int unsigned r;
    int unsigned m;
    logic [3:0]  mt;
    logic [3:0]  st;
    r  = s;
    m  = 0;
    mt = '0;
    st = '0;
    for (int i = 0; i < 100; i++) if (r >= 60) begin r -= 60; m++; end
    for (int i = 0; i < 10; i++) if (m >= 10) begin m -= 10; mt = mt + 4'd1; end
    for (int i = 0; i < 6; i++) if (r >= 10) begin r -= 10; st = st + 4'd1; end
    return {mt, 4'(m), st, 4'(r)};
  endfunction

  // BCD mm:ss decrement; the caller guarantees the value is nonzero.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd0) r[3:0] = v[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (v[7:4] != 4'd0) r[7:4] = v[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (v[11:8] != 4'd0) r[11:8] = v[11:8] - 4'd1;
        else begin
          r[11:8]  = 4'd9;
          r[15:12] = v[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // BCD mm:ss increment; the caller guarantees the value is below saturation.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      if (v[7:4] != 4'd5) r[7:4] = v[7:4] + 4'd1;
      else begin
        r[7:4] = 4'd0;
        if (v[11:8] != 4'd9) r[11:8] = v[11:8] + 4'd1;
        else begin
          r[11:8]  = 4'd0;
          r[15:12] = v[15:12] + 4'd1;
        end
      end
    end
    return r;
  endfunction

  localparam int unsigned PW         = $clog2(TICK_DIV);
  localparam logic [15:0] BOOST_BCD  = sec_to_bcd(BOOST_SEC);
  localparam logic [15:0] MAX_BCD    = sec_to_bcd(MAX_MIN * 60 + 59);
  localparam logic [15:0] REMIND_BCD = sec_to_bcd(REMIND_MIN * 60);
  localparam logic [7:0]  REMIND_MM  = REMIND_BCD[15:8];

  typedef enum logic [1:0] {IDLE, RUN, BOOST, HOLD} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    lvl_q, lvl_d;
  logic [15:0]   cd_q, cd_d;
  logic [3:0]    uses_q, uses_d;
  logic [15:0]   cum_q, cum_d;
  logic          remind_q, remind_d;
  logic          req_lvl, req_boost;

  assign req_lvl   = (mode_req != 3'd0) && (32'(mode_req) <= LEVELS);
  assign req_boost = (32'(mode_req) == LEVELS + 1);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      lvl_q    <= '0;
      cd_q     <= '0;
      uses_q   <= '0;
      cum_q    <= '0;
      remind_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      lvl_q    <= lvl_d;
      cd_q     <= cd_d;
      uses_q   <= uses_d;
      cum_q    <= cum_d;
      remind_q <= remind_d;
    end
  end

  // Next state: mode arbitration, boost entry/countdown and use accounting.
  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    cd_d    = cd_q;
    uses_d  = uses_q;
    case (state_q)
      IDLE, RUN: begin
        if (req_boost) begin
          if (boost_locked) state_d = HOLD;
          else begin
            state_d = BOOST;
            cd_d    = BOOST_BCD;
            uses_d  = uses_q + 4'd1;
          end
        end else if (req_lvl) begin
          state_d = RUN;
          lvl_d   = mode_req;
        end else begin
          state_d = IDLE;
        end
      end
      BOOST: begin
        if (!req_boost) begin
          state_d = req_lvl ? RUN : IDLE;
          if (req_lvl) lvl_d = mode_req;
        end else if (tick) begin
          if (cd_q == 16'h0000) state_d = HOLD;
          else cd_d = bcd_dec(cd_q);
        end
      end
      HOLD: begin
        if (!req_boost) begin
          state_d = req_lvl ? RUN : IDLE;
          if (req_lvl) lvl_d = mode_req;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef BOOST_REARM_EN
    if (clear_run) uses_d = '0;
`else
`endif
  end

  // Outputs decoded from the registered state.
  always_comb begin
    tick         = (presc_q == PW'(TICK_DIV - 1));
    boost_active = (state_q == BOOST);
    disp_sel     = (state_q == BOOST);
    boost_locked = (uses_q == 4'(BOOST_USES));
    remind       = remind_q;
    disp_bcd     = disp_sel ? cd_q : cum_q;
    case (state_q)
      IDLE:    fan_level = 3'd0;
      RUN:     fan_level = lvl_q;
      default: fan_level = 3'(LEVELS);
    endcase
  end

  // Prescaler, saturating cumulative run time and sticky reminder.
  always_comb begin
    presc_d  = tick ? '0 : presc_q + PW'(1);
    cum_d    = cum_q;
    remind_d = remind_q;
    if (clear_run) begin
      cum_d    = '0;
      remind_d = 1'b0;
    end else begin
      if (tick && (fan_level != 3'd0) && (cum_q != MAX_BCD)) cum_d = bcd_inc(cum_q);
      if (cum_d[15:8] >= REMIND_MM) remind_d = 1'b1;
    end
  end

endmodule
